// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// Owner, FSM state, operation and request bundle definitions.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t               op;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

    function automatic arb_owner_t other_owner(input arb_owner_t o);
        return (o == OWNER_I) ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising CPU I and D ports onto one word port.
// One request is latched per grant and replayed on pmem until pmem_resp.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [DATA_W/8-1:0] mem_byte_enable_i,
    input  logic [ADDR_W-1:0]   mem_address_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic                mem_resp_i,
    output logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_read_d,
    input  logic                mem_write_d,
    input  logic [DATA_W/8-1:0] mem_byte_enable_d,
    input  logic [ADDR_W-1:0]   mem_address_d,
    input  logic [DATA_W-1:0]   mem_wdata_d,
    output logic                mem_resp_d,
    output logic [DATA_W-1:0]   mem_rdata_d,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [DATA_W/8-1:0] pmem_byte_enable,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    input  logic                pmem_resp,
    input  logic [DATA_W-1:0]   pmem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state;
    arb_owner_t          last_grant;
    arb_owner_t          owner;
    mem_op_t             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     be;
    logic                cancelled;

    logic                pend_i;
    logic                pend_d;
    logic                grant_v;
    arb_owner_t          grant;
    logic                g_write;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [BE_W-1:0]     g_be;
    logic                owner_pend;
    logic                busy;
    logic                done;

    assign pend_i  = mem_read_i | mem_write_i;
    assign pend_d  = mem_read_d | mem_write_d;
    assign grant_v = pend_i | pend_d;

    always_comb begin
        grant = OWNER_I;
        unique case ({pend_i, pend_d})
            2'b11:   grant = other_owner(last_grant);
            2'b01:   grant = OWNER_D;
            default: grant = OWNER_I;
        endcase
    end

    // Write wins over a simultaneous read; the read stays pending.
    always_comb begin
        g_write = mem_write_i;
        g_addr  = mem_address_i;
        g_wdata = mem_wdata_i;
        g_be    = mem_byte_enable_i;
        if (grant == OWNER_D) begin
            g_write = mem_write_d;
            g_addr  = mem_address_d;
            g_wdata = mem_wdata_d;
            g_be    = mem_byte_enable_d;
        end
    end

    assign owner_pend = (owner == OWNER_I) ? pend_i : pend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= OWNER_D;
            owner      <= OWNER_I;
            op         <= OP_READ;
            addr       <= '0;
            wdata      <= '0;
            be         <= '0;
            cancelled  <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_v) begin
                        owner      <= grant;
                        last_grant <= grant;
                        op         <= g_write ? OP_WRITE : OP_READ;
                        addr       <= g_addr;
                        wdata      <= g_wdata;
                        be         <= g_be;
                        cancelled  <= 1'b0;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A dropped request stays dropped even if reasserted.
                    if (!owner_pend)
                        cancelled <= 1'b1;
                    if (pmem_resp)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign busy = (state == ARB_BUSY);
    assign done = busy & pmem_resp & owner_pend & ~cancelled;

    assign pmem_read        = busy & (op == OP_READ);
    assign pmem_write       = busy & (op == OP_WRITE);
    assign pmem_address     = addr;
    assign pmem_wdata       = wdata;
    assign pmem_byte_enable = be;

    assign mem_resp_i  = done & (owner == OWNER_I);
    assign mem_resp_d  = done & (owner == OWNER_D);
    assign mem_rdata_i = (mem_resp_i && op == OP_READ) ? pmem_rdata : '0;
    assign mem_rdata_d = (mem_resp_d && op == OP_READ) ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural lower memory.
// Drivers push expected responses; a monitor pops them on each resp.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [3:0]  mem_byte_enable_i;
    logic [31:0] mem_address_i, mem_wdata_i;
    logic        mem_resp_i;
    logic [31:0] mem_rdata_i;
    logic        mem_read_d, mem_write_d;
    logic [3:0]  mem_byte_enable_d;
    logic [31:0] mem_address_d, mem_wdata_d;
    logic        mem_resp_d;
    logic [31:0] mem_rdata_d;
    logic        pmem_read, pmem_write;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_address, pmem_wdata;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_byte_enable_i(mem_byte_enable_i),
        .mem_address_i(mem_address_i), .mem_wdata_i(mem_wdata_i),
        .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
        .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .mem_byte_enable_d(mem_byte_enable_d),
        .mem_address_d(mem_address_d), .mem_wdata_d(mem_wdata_d),
        .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_req_t    req;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    bit   order[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mem_delay = 1;
    bit   mem_rand = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h60)
            return 32'h0000_0013;
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lower-level memory: answers each pmem request after a delay.
    initial begin
        int cnt;
        bit active;
        active = 0;
        cnt = 0;
        pmem_resp = 0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                active = 0;
                pmem_resp = 0;
                pmem_rdata = '0;
            end else if (pmem_resp) begin
                pmem_resp = 0;
                pmem_rdata = '0;
            end else if (pmem_read | pmem_write) begin
                if (!active) begin
                    active = 1;
                    cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
                end
                if (cnt == 0) begin
                    pmem_resp = 1;
                    pmem_rdata = pmem_read ? mem_val(pmem_address) : 32'hBAD0_0001;
                    active = 0;
                end else begin
                    cnt--;
                end
            end else begin
                active = 0;
            end
        end
    end

    task automatic check_resp(input bit p);
        exp_t e;
        if ((p ? exp_d.size() : exp_i.size()) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp port %0d: got resp expected none at %0t", p, $time);
            return;
        end
        e = p ? exp_d.pop_front() : exp_i.pop_front();
        order.push_back(p);
        chk(p ? "rdata_d" : "rdata_i", p ? mem_rdata_d : mem_rdata_i, e.rdata);
        chk("pmem_write", {31'b0, pmem_write}, {31'b0, e.req.op == OP_WRITE});
        chk("pmem_read", {31'b0, pmem_read}, {31'b0, e.req.op == OP_READ});
        chk("pmem_address", pmem_address, e.req.addr);
        if (e.req.op == OP_WRITE) begin
            chk("pmem_wdata", pmem_wdata, e.req.wdata);
            chk("pmem_be", {28'b0, pmem_byte_enable}, {28'b0, e.req.be});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pmem_rw_excl", {31'b0, pmem_read & pmem_write}, 32'h0);
                chk("resp_excl", {31'b0, mem_resp_i & mem_resp_d}, 32'h0);
                if (mem_resp_i) check_resp(1'b0);
                if (mem_resp_d) check_resp(1'b1);
            end
        end
    end

    task automatic req(input bit p, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input bit push);
        exp_t e;
        e.req.op    = wr ? OP_WRITE : OP_READ;
        e.req.addr  = a;
        e.req.wdata = wd;
        e.req.be    = be;
        e.rdata     = wr ? 32'h0 : mem_val(a);
        if (p) begin
            mem_read_d = rd; mem_write_d = wr; mem_address_d = a;
            mem_wdata_d = wd; mem_byte_enable_d = be;
            if (push) exp_d.push_back(e);
        end else begin
            mem_read_i = rd; mem_write_i = wr; mem_address_i = a;
            mem_wdata_i = wd; mem_byte_enable_i = be;
            if (push) exp_i.push_back(e);
        end
    endtask

    task automatic clear(input bit p);
        if (p) begin
            mem_read_d = 0; mem_write_d = 0;
        end else begin
            mem_read_i = 0; mem_write_i = 0;
        end
    endtask

    task automatic wait_resp(input bit p);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = p ? mem_resp_d : mem_resp_i;
        end
        if (!got) chk(p ? "timeout_d" : "timeout_i", 32'h0, 32'h1);
    endtask

    task automatic serve(input bit p);
        wait_resp(p);
        @(posedge clk);
        #1;
        clear(p);
    endtask

    task automatic stress(input bit p, input int n);
        bit w;
        for (int k = 0; k < n; k++) begin
            w = 1'($urandom_range(0, 1));
            req(p, !w, w, {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                $urandom, 4'($urandom_range(1, 15)), 1);
            wait_resp(p);
            @(posedge clk);
            #1;
        end
        clear(p);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int n;
        rst = 1;
        mem_read_i = 0; mem_write_i = 0; mem_byte_enable_i = 0;
        mem_address_i = 0; mem_wdata_i = 0;
        mem_read_d = 0; mem_write_d = 0; mem_byte_enable_d = 0;
        mem_address_d = 0; mem_wdata_d = 0;

        repeat (2) @(negedge clk);
        chk("rst_pmem_read", {31'b0, pmem_read}, 32'h0);
        chk("rst_pmem_write", {31'b0, pmem_write}, 32'h0);
        chk("rst_resp", {30'b0, mem_resp_i, mem_resp_d}, 32'h0);
        chk("rst_address", pmem_address, 32'h0);
        chk("rst_wdata", pmem_wdata, 32'h0);
        chk("rst_rdata", mem_rdata_i | mem_rdata_d, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;

        // Single I read with a 3-cycle memory.
        mem_delay = 3;
        @(posedge clk);
        #1;
        req(0, 1, 0, 32'h60, 0, 4'hF, 1);
        @(negedge clk);
        chk("grant_cycle_idle", {31'b0, pmem_read}, 32'h0);
        @(negedge clk);
        chk("busy_pmem_read", {31'b0, pmem_read}, 32'h1);
        chk("busy_pmem_addr", pmem_address, 32'h60);
        serve(0);

        // Simultaneous requests after reset: I first, then D.
        do_reset();
        mem_delay = 1;
        order.delete();
        req(0, 1, 0, 32'h100, 0, 4'hF, 1);
        req(1, 0, 1, 32'h200, 32'hDEADBEEF, 4'hF, 1);
        fork
            serve(0);
            serve(1);
        join
        chk("simul_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("simul_first", {31'b0, order[0]}, 32'h0);
            chk("simul_second", {31'b0, order[1]}, 32'h1);
        end

        // D read and write together: write first, read stays pending.
        @(posedge clk);
        #1;
        req(1, 1, 1, 32'h300, 32'hCAFEF00D, 4'h3, 1);
        wait_resp(1);
        @(posedge clk);
        #1;
        req(1, 1, 0, 32'h304, 0, 4'hF, 1);
        serve(1);

        // Fetch flush: no resp to I, then a D read is served.
        mem_delay = 5;
        @(posedge clk);
        #1;
        req(0, 1, 0, 32'h40, 0, 4'hF, 0);
        repeat (2) @(posedge clk);
        #1;
        clear(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_resp && n < 50);
        chk("flush_pmem_resp", {31'b0, pmem_resp}, 32'h1);
        chk("flush_no_resp_i", {31'b0, mem_resp_i}, 32'h0);
        @(negedge clk);
        chk("flush_back_idle", {31'b0, pmem_read | pmem_write}, 32'h0);
        mem_delay = 1;
        @(posedge clk);
        #1;
        req(1, 1, 0, 32'h80, 0, 4'hF, 1);
        serve(1);

        // Fairness stress with random memory latency.
        mem_rand = 1;
        order.delete();
        @(posedge clk);
        #1;
        fork
            stress(0, 10);
            stress(1, 10);
        join
        mem_rand = 0;
        chk("stress_count", order.size(), 20);
        for (int i = 1; i < order.size(); i++)
            chk("alternate", {31'b0, order[i]}, {31'b0, !order[i-1]});

        // Reset while BUSY aborts the transaction.
        mem_delay = 10;
        @(posedge clk);
        #1;
        req(0, 1, 0, 32'h500, 0, 4'hF, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_read && n < 20);
        chk("pre_rst_busy", {31'b0, pmem_read}, 32'h1);
        #2;
        rst = 1;
        #1;
        chk("async_rst_read", {31'b0, pmem_read}, 32'h0);
        chk("async_rst_addr", pmem_address, 32'h0);
        chk("async_rst_resp", {30'b0, mem_resp_i, mem_resp_d}, 32'h0);
        clear(0);
        @(posedge clk);
        #1;
        rst = 0;
        mem_delay = 1;
        @(posedge clk);
        #1;
        req(0, 1, 0, 32'h64, 0, 4'hF, 1);
        serve(0);

        repeat (3) @(posedge clk);
        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder for the CPU's two memory ports. The instruction port carries mem_*_i and the data port carries mem_*_d; the arbiter serves both.
- It serialises their requests onto a single lower-level word memory port, pmem_*.
- It sits between the cpu top level and main memory (or the L2/cache below).
- Fairness is round-robin: when both ports are pending, the port that did not win the last grant is served.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read_i  in  1  I-port read request; held until mem_resp_i
- mem_write_i  in  1  I-port write request; the CPU ties it 0, but it is honoured
- mem_byte_enable_i  in  DATA_W/8  I-port byte enables
- mem_address_i  in  ADDR_W  I-port address
- mem_wdata_i  in  DATA_W  I-port write data
- mem_resp_i  out  1  one-cycle completion pulse to the I-port
- mem_rdata_i  out  DATA_W  I-port read data, valid when mem_resp_i=1
- mem_read_d, mem_write_d, mem_byte_enable_d, mem_address_d, mem_wdata_d  in  same widths as the I-port  D-port request
- mem_resp_d  out  1  one-cycle completion pulse to the D-port
- mem_rdata_d  out  DATA_W  D-port read data
- pmem_read  out  1  lower-level read request
- pmem_write  out  1  lower-level write request
- pmem_byte_enable  out  DATA_W/8  lower-level byte enables
- pmem_address  out  ADDR_W  lower-level address
- pmem_wdata  out  DATA_W  lower-level write data
- pmem_resp  in  1  lower-level completion pulse
- pmem_rdata  in  DATA_W  lower-level read data

Behaviour:
- States:
  - IDLE: no transaction in flight.
  - BUSY: one latched transaction is driven on pmem.
- Registers:
  - Request latch: op (READ/WRITE), owner (I/D), address, wdata, byte_enable.
  - last_grant: 1 bit, the owner of the most recent grant.
- Reset (async, rst=1):
  - state=IDLE, last_grant=D, latch cleared.
  - All outputs 0: pmem_read, pmem_write, mem_resp_i, mem_resp_d, and all rdata, address and wdata fields.
- IDLE:
  - A port is pending when its read | write is high.
  - If only one port is pending, grant it. If both are pending, grant the port that is not last_grant.
  - On grant: latch that port's request, set last_grant, go to BUSY on the next edge.
  - pmem_read/pmem_write are 0 in IDLE.
  - The grant decision costs one cycle. Minimum latency from request to resp is 2 cycles (pmem_resp on the first BUSY cycle).
- Op selection when a port asserts read and write together:
  - WRITE wins; the read remains pending.
  - The CPU muxes mem_address_d by mem_write_d, so this matches its address selection.
- BUSY:
  - pmem_* are driven from the latch only. Inputs changing mid-transaction have no effect.
  - On pmem_resp=1, in the same cycle (combinational):
    - Pulse the owner's mem_resp_x.
    - Drive mem_rdata_x=pmem_rdata; it is don't-care for writes, but the bench checks 0 on writes.
    - Return to IDLE on the next edge.
- Cancelled requests (e.g. the CPU flushes fetch):
  - If the owner drops both read and write before pmem_resp, the pmem transaction still completes.
  - The resp pulse to that owner is suppressed.
  - A write is never cancelled at pmem.
- Back-to-back requests:
  - The requester samples resp at the edge and may present a new request immediately.
  - The arbiter sees it in IDLE on the following cycle. No request is lost or duplicated.
  - A port holding its request after resp is treated as a new request.
- The non-owner port never receives resp. Its request waits, with address and data unchanged, until granted.
- mem_resp_i and mem_resp_d are never both 1 in the same cycle.
- pmem_read and pmem_write are never both 1 in the same cycle.
- rst asserted in BUSY aborts the transaction: outputs go to 0 immediately. The lower level must tolerate the withdrawn request.

Decomposition:
- Shared package (rv32i_types or a new mem_types):
  - typedef arb_owner_t {OWNER_I, OWNER_D}
  - typedef arb_state_t {ARB_IDLE, ARB_BUSY}
  - struct mem_req_t {op, addr, wdata, be}
- Sub-module: none needed. A single module holds the FSM, the request latch and the round-robin select.

Test Plan:
- Single I read: mem_read_i=1, addr 0x60, pmem_resp after 3 cycles with rdata 0x00000013 -> pmem_read=1 with addr 0x60 from cycle 1; mem_resp_i pulses one cycle with mem_rdata_i=0x00000013; mem_resp_d stays 0.
- Simultaneous requests: I read 0x100 and D write 0x200 (wdata 0xDEADBEEF, be 0xF) asserted in the same cycle after reset, last_grant=D -> I is served first, then D; pmem_write carries 0x200/0xDEADBEEF; exactly one resp per port.
- D-port read and write together: read/write both 1, addr 0x300 (write address) -> WRITE issued first with resp_d; read remains pending and is served next.
- Flush cancel: I read 0x40 granted, mem_read_i dropped two cycles later, pmem_resp arrives -> no mem_resp_i pulse; arbiter returns to IDLE; a following D read at 0x80 is served normally.
- Fairness stress: both ports re-request immediately after each resp for 20 transactions -> grants strictly alternate I, D, I, D…; no pmem_read/pmem_write overlap.
- Reset mid-BUSY: rst pulsed while pmem_read=1 -> all outputs 0 asynchronously, state IDLE; a fresh I read after release completes normally.
